// File: rtl/nibble_adder_pkg.sv
// Shared definitions for the nibble-serial adder: slice width, FSM states and
// the operand-width legality check used at elaboration.
package nibble_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    function automatic bit width_ok(input int w);
        return (w >= NIBBLE_W) && ((w % NIBBLE_W) == 0);
    endfunction

endpackage

// File: rtl/nibble_adder.sv
// Combinational 4-bit ripple-carry slice; one carry-out for the whole nibble.
module nibble_adder
    import nibble_adder_pkg::*;
(
    output logic [NIBBLE_W-1:0] sum,
    output logic                c_out,
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                c_in
);

    always_comb begin
        logic c;
        sum = '0;
        c   = c_in;
        for (int i = 0; i < NIBBLE_W; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        c_out = c;
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder built from one 4-bit slice, stepping LS nibble first with the
// carry held in a register between steps; result published only on completion.
module nibble_serial_adder
    import nibble_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
    end

    state_t                state;
    logic [IDX_W-1:0]      idx;
    logic                  carry_r;
    logic [WIDTH-1:0]      a_r;
    logic [WIDTH-1:0]      b_r;
    logic [WIDTH-1:0]      acc;
    logic [WIDTH-1:0]      acc_next;
    logic [NIBBLE_W-1:0]   a_nib;
    logic [NIBBLE_W-1:0]   b_nib;
    logic [NIBBLE_W-1:0]   s_nib;
    logic                  co_nib;

    nibble_adder u_slice (
        .sum   (s_nib),
        .c_out (co_nib),
        .a     (a_nib),
        .b     (b_nib),
        .c_in  (carry_r)
    );

    // Merge the nibble being produced this cycle so the final step can publish
    // the full result in the same edge that writes its last nibble.
    always_comb begin
        a_nib    = a_r[idx*NIBBLE_W +: NIBBLE_W];
        b_nib    = b_r[idx*NIBBLE_W +: NIBBLE_W];
        acc_next = acc;
        acc_next[idx*NIBBLE_W +: NIBBLE_W] = s_nib;
    end

    assign ready = (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            carry_r  <= 1'b0;
            a_r      <= '0;
            b_r      <= '0;
            acc      <= '0;
            done     <= 1'b0;
            sum      <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b;
                        carry_r <= c_in;
                        idx     <= '0;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    acc     <= acc_next;
                    carry_r <= co_nib;
                    if (idx == LAST_IDX) begin
                        sum      <= acc_next;
                        c_out    <= co_nib;
                        overflow <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                                    (acc_next[WIDTH-1] != a_r[WIDTH-1]);
                        done     <= 1'b1;
                        idx      <= '0;
                        state    <= IDLE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder at WIDTH=16 (directed), 4 and 32 (random/corner).
module tb_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] a_bus = '0;
    logic [31:0] b_bus = '0;
    logic        cin_bus = 1'b0;
    logic        start4 = 1'b0, start16 = 1'b0, start32 = 1'b0;

    logic        ready4, done4, co4, ov4;
    logic [3:0]  sum4;
    logic        ready16, done16, co16, ov16;
    logic [15:0] sum16;
    logic        ready32, done32, co32, ov32;
    logic [31:0] sum32;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a_bus[3:0]), .b(b_bus[3:0]),
        .c_in(cin_bus), .ready(ready4), .done(done4), .sum(sum4),
        .c_out(co4), .overflow(ov4)
    );
    nibble_serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a_bus[15:0]), .b(b_bus[15:0]),
        .c_in(cin_bus), .ready(ready16), .done(done16), .sum(sum16),
        .c_out(co16), .overflow(ov16)
    );
    nibble_serial_adder #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .a(a_bus), .b(b_bus),
        .c_in(cin_bus), .ready(ready32), .done(done32), .sum(sum32),
        .c_out(co32), .overflow(ov32)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        co;
        logic        ov;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One request on the selected instance; lat counts edges from acceptance to done.
    task automatic run_op(input int w, input logic [31:0] av, input logic [31:0] bv,
                          input logic cv, output logic [31:0] s, output logic co,
                          output logic ov, output int lat);
        logic d;
        @(negedge clk);
        a_bus = av; b_bus = bv; cin_bus = cv;
        start4 = (w == 4); start16 = (w == 16); start32 = (w == 32);
        @(posedge clk);
        #1;
        start4 = 1'b0; start16 = 1'b0; start32 = 1'b0;
        lat = 0;
        d = 1'b0;
        while (!d && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            d = (w == 4) ? done4 : (w == 16) ? done16 : done32;
        end
        case (w)
            4:       begin s = {28'd0, sum4};  co = co4;  ov = ov4;  end
            16:      begin s = {16'd0, sum16}; co = co16; ov = ov16; end
            default: begin s = sum32;          co = co32; ov = ov32; end
        endcase
    endtask

    // Reference: plain wide arithmetic plus the sign rule for overflow.
    task automatic model(input int w, input logic [31:0] av, input logic [31:0] bv,
                         input logic cv, output logic [31:0] s, output logic co,
                         output logic ov);
        logic [63:0] mask, full;
        logic sa, sb, ss;
        mask = (64'd1 << w) - 64'd1;
        full = ({32'd0, av} & mask) + ({32'd0, bv} & mask) + {63'd0, cv};
        s    = 32'(full & mask);
        co   = full[w];
        sa = av[w-1]; sb = bv[w-1]; ss = s[w-1];
        ov = (sa == sb) && (ss != sa);
    endtask

    initial begin
        vec_t        vecs[6];
        logic [31:0] s, es;
        logic        co, ov, eco, eov;
        int          lat, ndone, first_cyc, unstable;
        logic [15:0] s1, s2;

        vecs[0] = '{16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[5] = '{16'h0800, 16'h0700, 1'b0, 16'h0F00, 1'b0, 1'b0};

        repeat (2) @(negedge clk);
        check("rst_ready", ready16, 1);
        check("rst_done", done16, 0);
        check("rst_sum", sum16, 0);
        check("rst_cout", co16, 0);
        check("rst_ovf", ov16, 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_op(16, {16'd0, vecs[i].a}, {16'd0, vecs[i].b}, vecs[i].cin, s, co, ov, lat);
            check($sformatf("vec%0d_sum", i), s, {16'd0, vecs[i].sum});
            check($sformatf("vec%0d_cout", i), co, vecs[i].co);
            check($sformatf("vec%0d_ovf", i), ov, vecs[i].ov);
            check($sformatf("vec%0d_latency", i), lat, 4);
        end

        // Operands churn and start is pulsed while busy: one done, original result.
        @(negedge clk);
        a_bus = 32'h1234; b_bus = 32'h4321; cin_bus = 1'b1; start16 = 1'b1;
        @(posedge clk);
        #1;
        a_bus = $urandom; b_bus = $urandom; cin_bus = 1'($urandom);
        ndone = 0; s1 = '0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (done16) begin ndone++; s1 = sum16; end
            if (!ready16) begin
                a_bus = $urandom; b_bus = $urandom; cin_bus = 1'($urandom); start16 = 1'b1;
            end else begin
                start16 = 1'b0;
            end
        end
        start16 = 1'b0;
        check("busy_done_count", ndone, 1);
        check("busy_sum", s1, 16'h5556);

        // start held high: two back-to-back operations, sum steady in between.
        @(negedge clk);
        a_bus = 32'h1; b_bus = 32'h1; cin_bus = 1'b0; start16 = 1'b1;
        @(posedge clk);
        #1;
        a_bus = 32'h0800; b_bus = 32'h0700;
        ndone = 0; first_cyc = 0; unstable = 0; s1 = '0; s2 = '0;
        for (int c = 1; c <= 15 && ndone < 2; c++) begin
            @(posedge clk);
            #1;
            if (done16) begin
                ndone++;
                if (ndone == 1) begin s1 = sum16; first_cyc = c; end
                else begin s2 = sum16; start16 = 1'b0; end
            end else if (ndone == 1 && sum16 !== 16'h0002) begin
                unstable++;
            end
        end
        start16 = 1'b0;
        check("held_done_count", ndone, 2);
        check("held_first_latency", first_cyc, 4);
        check("held_sum1", s1, 16'h0002);
        check("held_sum2", s2, 16'h0F00);
        check("held_sum_unstable", unstable, 0);

        // Reset during the second CALC cycle aborts the request.
        @(negedge clk);
        a_bus = 32'hFFFF; b_bus = 32'hFFFF; cin_bus = 1'b0; start16 = 1'b1;
        @(posedge clk);
        #1;
        start16 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_ready", ready16, 1);
        check("abort_done", done16, 0);
        check("abort_sum", sum16, 0);
        check("abort_cout", co16, 0);
        check("abort_ovf", ov16, 0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (done16) ndone++;
        end
        check("abort_no_done", ndone, 0);
        run_op(16, 32'h3, 32'h4, 1'b0, s, co, ov, lat);
        check("after_abort_sum", s, 32'h7);
        check("after_abort_latency", lat, 4);

        // Single-nibble instance.
        run_op(4, 32'hF, 32'h1, 1'b1, s, co, ov, lat);
        check("w4_sum", s, 32'h1);
        check("w4_cout", co, 1);
        check("w4_ovf", ov, 0);
        check("w4_latency", lat, 1);

        for (int n = 0; n < 1000; n++) begin
            for (int k = 0; k < 2; k++) begin
                int w;
                logic [31:0] av, bv;
                logic cv;
                w  = (k == 0) ? 16 : 32;
                av = $urandom; bv = $urandom; cv = 1'($urandom);
                if ((n % 10) == 0) bv = ~av;
                if (w == 16) begin av[31:16] = '0; bv[31:16] = '0; end
                model(w, av, bv, cv, es, eco, eov);
                run_op(w, av, bv, cv, s, co, ov, lat);
                check($sformatf("rand_w%0d_sum", w), s, es);
                check($sformatf("rand_w%0d_cout", w), co, eco);
                check($sformatf("rand_w%0d_ovf", w), ov, eov);
                check($sformatf("rand_w%0d_latency", w), lat, w / 4);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle WIDTH-bit adder that reuses a single 4-bit adder stage, one nibble per clock, least-significant nibble first. It sits directly upstream of the 4-bit adder slice. It latches the wide operands, feeds the slice one nibble at a time and chains the carry through a register. It collects the slice's sum nibbles into a wide result. It trades latency for area where a full-width adder is too large.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and ≥ 4
- NIBBLES, WIDTH/4, derived, number of nibble steps (not overridable)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset (one clock; reset is asynchronous and active-high)
- start  in  1  request; accepted only on a clk edge where ready=1
- a  in  WIDTH  operand A, sampled on the accepting edge only
- b  in  WIDTH  operand B, sampled on the accepting edge only
- c_in  in  1  carry into nibble 0, sampled on the accepting edge only
- ready  out  1  high in IDLE; reset value 1
- done  out  1  one-cycle pulse, result valid; reset value 0
- sum  out  WIDTH  result; reset value 0; holds until the next completion
- c_out  out  1  carry out of the MSB; reset value 0
- overflow  out  1  two's-complement overflow; reset value 0

## Operation
- States: IDLE, CALC. Reset forces IDLE, idx=0, carry register=0 and all outputs to their reset values.
- IDLE with start=1:
  - latch a, b and c_in into operand registers; the carry register takes c_in.
  - idx=0, go to CALC.
- IDLE with start=0: stay in IDLE.
- CALC, each cycle:
  - drive the slice with a_r[4*idx+3:4*idx], b_r[4*idx+3:4*idx] and the carry register.
  - write the slice's 4-bit sum into the internal accumulator at the same nibble position.
  - the carry register takes the slice's single carry-out.
  - idx increments.
- CALC with idx=NIBBLES-1:
  - copy the accumulator (with the final nibble) to sum.
  - c_out = final carry-out.
  - overflow = (a_r[WIDTH-1]==b_r[WIDTH-1]) && (sum[WIDTH-1]!=a_r[WIDTH-1]).
  - done=1 for the next cycle; return to IDLE.
- Arithmetic: {c_out,sum} = a + b + c_in exactly, modulo 2^(WIDTH+1). No truncation of inter-nibble carries.
- start while in CALC is ignored. Operands are not re-sampled and no request is queued.
- a, b and c_in may change freely while busy; only the latched copies are used.
- sum, c_out and overflow change only on the completion edge; intermediate nibbles are never visible.

## Timing
- Accepting edge E0. Nibble k is computed in the cycle after edge E(k) and registered at E(k+1), for k=0..NIBBLES-1.
- Completion at edge E(NIBBLES): done=1, result valid and ready=1 during the cycle that follows.
- Latency: start to done = NIBBLES cycles. WIDTH=16 gives 4; WIDTH=4 gives 1.
- Back-to-back: start=1 in the done cycle is accepted. done drops the next cycle, and the previous sum holds until the new completion.
- Throughput: one operation per NIBBLES cycles.
- Reset asserted mid-CALC:
  - immediate IDLE and ready=1.
  - done=0, sum/c_out/overflow=0.
  - no later done pulse for the aborted request.
- Reset released on an edge where start=1: start is not accepted on that edge.

## Structure
- Package nibble_adder_pkg holds:
  - NIBBLE_W = 4.
  - state enum {IDLE, CALC}.
  - an elaboration check that WIDTH % NIBBLE_W == 0.
- Sub-module nibble_adder: combinational 4-bit slice (sum[3:0], c_out, a[3:0], b[3:0], c_in).
  - Full carry chain: each bit's carry-in is the previous bit's carry-out.
  - Exactly one carry-out bit.
  - Instantiated once.
- idx counter width: $clog2(NIBBLES), minimum 1.

## Test plan
- WIDTH=16, a=0x00F0, b=0x0010, c_in=0 -> sum=0x0100, c_out=0, overflow=0, done exactly 4 cycles after the accepting edge. Exercises carry into nibble 2.
- a=0xFFFF, b=0x0001, c_in=0 -> sum=0x0000, c_out=1, overflow=0. Then a=0x7FFF, b=0x0001 -> sum=0x8000, c_out=0, overflow=1.
- a=0x1234, b=0x4321, c_in=1 -> sum=0x5556, c_out=0. Operands change every cycle while busy -> result unaffected. start pulsed during CALC -> ignored, exactly one done.
- start held high continuously -> done every 4 cycles. Results: sum is 0x0002 for 1+1, then 0x0F00 for 0x0800+0x0700, and sum stays stable between done pulses.
- rst asserted during the 2nd CALC cycle of a 0xFFFF+0xFFFF request -> ready=1, sum=0, done=0. No done for 8 cycles. A new request 0x0003+0x0004 -> 0x0007.
- WIDTH=4: a=0xF, b=0x1, c_in=1 -> sum=0x1, c_out=1, done 1 cycle after acceptance. Also a randomized 1000-op compare against a+b+c_in at WIDTH=16 and WIDTH=32.
